// File: rtl/vram_port_sched_pkg.sv
// Shared constants and types for the VRAM port-A scheduler: memory map of the
// two tile screens, bus widths and the fill-engine state encoding.
package vram_port_sched_pkg;

   localparam int ADDR_W    = 14;     // VRAM word-address width
   localparam int DATA_W    = 32;     // VRAM word width
   localparam int SCR0_BASE = 2048;   // first word of screen 0 (80x60 tiles)
   localparam int SCR1_BASE = 6848;   // first word of screen 1
   localparam int SCR_WORDS = 4800;   // words per screen
   localparam int CNT_W     = 13;     // fill word counter width, holds 0..SCR_WORDS-1

   typedef enum logic [1:0] {
      FILL_IDLE = 2'd0,
      FILL_RUN  = 2'd1,
      FILL_DONE = 2'd2
   } fill_state_t;

   // Start address of the selected screen, sized to the VRAM address bus.
   function automatic logic [ADDR_W-1:0] screen_base(input logic screen);
      logic [ADDR_W-1:0] base;
      if (screen) begin
         base = ADDR_W'(SCR1_BASE);
      end else begin
         base = ADDR_W'(SCR0_BASE);
      end
      return base;
   endfunction

endpackage

// File: rtl/vram_port_sched_fill.sv
// Screen-fill engine: walks every word of one screen writing a constant value.
// It raises req while it has a word to write and advances only on grant, so it
// tolerates any amount of interleaved CPU traffic.
module vram_port_sched_fill
   import vram_port_sched_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              fill_start,
   input  logic              fill_screen,
   input  logic [DATA_W-1:0] fill_value,
   input  logic              grant,
   output logic              req,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] wdata,
   output logic              busy,
   output logic              done
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SCR_WORDS - 1);

   fill_state_t       state_r, state_s;
   logic [CNT_W-1:0]  cnt_r, cnt_s;
   logic [ADDR_W-1:0] base_r, base_s;
   logic [DATA_W-1:0] value_r, value_s;

   // State, counter and latched fill parameters; reset abandons any fill silently.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r <= FILL_IDLE;
         cnt_r   <= '0;
         base_r  <= '0;
         value_r <= '0;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         base_r  <= base_s;
         value_r <= value_s;
      end
   end

   // Next-state logic: a new start is only accepted from IDLE.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      base_s  = base_r;
      value_s = value_r;
      case (state_r)
         FILL_IDLE: begin
            if (fill_start) begin
               state_s = FILL_RUN;
               cnt_s   = '0;
               base_s  = screen_base(fill_screen);
               value_s = fill_value;
            end else begin
               state_s = FILL_IDLE;
            end
         end
         FILL_RUN: begin
            if (grant) begin
               cnt_s = cnt_r + CNT_W'(1);
               if (cnt_r == LAST_CNT) begin
                  state_s = FILL_DONE;
               end else begin
                  state_s = FILL_RUN;
               end
            end else begin
               state_s = FILL_RUN;
            end
         end
         FILL_DONE: begin
            state_s = FILL_IDLE;
         end
         default: begin
            state_s = FILL_IDLE;
         end
      endcase
   end

   // Outputs decode directly from registered state, so they are glitch-free.
   assign req   = (state_r == FILL_RUN);
   assign busy  = (state_r == FILL_RUN);
   assign done  = (state_r == FILL_DONE);
   assign addr  = base_r + ADDR_W'(cnt_r);
   assign wdata = value_r;

endmodule

// File: rtl/vram_port_sched.sv
// Port-A owner of the tile VRAM. Arbitrates CPU loads/stores against the
// screen-fill engine, returns CPU completions one cycle after grant, and keeps
// the displayed-screen select stable except at a vsync falling edge.
module vram_port_sched
   import vram_port_sched_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_ack,
   input  logic              fill_start,
   input  logic              fill_screen,
   input  logic [DATA_W-1:0] fill_value,
   output logic              fill_busy,
   output logic              fill_done,
   input  logic              swap_req,
   input  logic              vga_vs,
   output logic              disp_sel,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);

   logic              cpu_grant_s;
   logic              fill_grant_s;
   logic              fill_req_s;
   logic [ADDR_W-1:0] fill_addr_s;
   logic [DATA_W-1:0] fill_wdata_s;
   logic              ack_r;
   logic              ack_we_r;
   logic              vs_prev_r;
   logic              vs_fall_s;
   logic              swap_pend_r;
   logic              disp_sel_r;

   vram_port_sched_fill u_fill (
      .clk         (clk),
      .rst         (rst),
      .fill_start  (fill_start),
      .fill_screen (fill_screen),
      .fill_value  (fill_value),
      .grant       (fill_grant_s),
      .req         (fill_req_s),
      .addr        (fill_addr_s),
      .wdata       (fill_wdata_s),
      .busy        (fill_busy),
      .done        (fill_done)
   );

   // The CPU is locked out during its own ack cycle, which hands that slot to
   // the fill engine and keeps a continuously requesting CPU from starving it.
   assign cpu_grant_s  = rst & cpu_req & ~ack_r;
   assign fill_grant_s = rst & fill_req_s & ~cpu_grant_s;

   // Steer port A from whichever requester holds the grant this cycle.
   always_comb begin
      ram_en    = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;
      if (cpu_grant_s) begin
         ram_en    = 1'b1;
         ram_we    = cpu_we;
         ram_addr  = cpu_addr;
         ram_wdata = cpu_we ? cpu_wdata : '0;
      end else if (fill_grant_s) begin
         ram_en    = 1'b1;
         ram_we    = 1'b1;
         ram_addr  = fill_addr_s;
         ram_wdata = fill_wdata_s;
      end else begin
         ram_en    = 1'b0;
      end
   end

   // Ack pipeline: remember a CPU grant for one cycle, aligned with RAM read data.
   always_ff @(posedge clk) begin
      if (!rst) begin
         ack_r    <= 1'b0;
         ack_we_r <= 1'b0;
      end else begin
         ack_r    <= cpu_grant_s;
         ack_we_r <= cpu_grant_s & cpu_we;
      end
   end

   assign cpu_ack   = ack_r;
   assign cpu_rdata = (ack_r & ~ack_we_r) ? ram_rdata : '0;

   // Vsync is active-low, so its falling edge marks the start of blanking.
   assign vs_fall_s = vs_prev_r & ~vga_vs;

   // Swap bookkeeping: requests collapse into one pending flag that is consumed
   // at the next vsync falling edge; a request on the edge cycle counts too.
   always_ff @(posedge clk) begin
      if (!rst) begin
         vs_prev_r   <= 1'b0;
         swap_pend_r <= 1'b0;
         disp_sel_r  <= 1'b0;
      end else begin
         vs_prev_r <= vga_vs;
         if (vs_fall_s && (swap_pend_r || swap_req)) begin
            disp_sel_r  <= ~disp_sel_r;
            swap_pend_r <= 1'b0;
         end else if (swap_req) begin
            swap_pend_r <= 1'b1;
         end
      end
   end

   assign disp_sel = disp_sel_r;

endmodule

// File: tb/tb_vram_port_sched.sv
// Directed bench for vram_port_sched with a behavioural synchronous VRAM on port A.
module tb_vram_port_sched;
   import vram_port_sched_pkg::*;

   logic              clk = 1'b0;
   logic              rst;
   logic              cpu_req, cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
   logic              cpu_ack;
   logic              fill_start, fill_screen;
   logic [DATA_W-1:0] fill_value;
   logic              fill_busy, fill_done;
   logic              swap_req, vga_vs, disp_sel;
   logic              ram_en, ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata = '0;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [31:0] mem [0:16383];
   bit          wr  [0:16383];

   always #5 clk = ~clk;

   vram_port_sched dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
      .fill_start(fill_start), .fill_screen(fill_screen), .fill_value(fill_value),
      .fill_busy(fill_busy), .fill_done(fill_done),
      .swap_req(swap_req), .vga_vs(vga_vs), .disp_sel(disp_sel),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata)
   );

   // Content of a word the bench never wrote: distinct per address.
   function automatic logic [31:0] dflt(input int a);
      return 32'hc0de0000 | 32'(a);
   endfunction

   // Synchronous single-port memory model: read data appears one cycle after ram_en.
   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
            wr[ram_addr]  <= 1'b1;
         end else begin
            ram_rdata <= wr[ram_addr] ? mem[ram_addr] : dflt(int'(ram_addr));
         end
      end
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      int good;
      int acks;
      int dones;
      int done_cycle;
      int busy_seen;
      bit ok;

      rst = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      fill_start = 1'b0; fill_screen = 1'b0; fill_value = '0;
      swap_req = 1'b0; vga_vs = 1'b1;

      // ---------------- reset state
      repeat (3) @(negedge clk);
      #1;
      check_val("reset_ram_en", 32'(ram_en), 32'd0);
      check_val("reset_cpu_ack", 32'(cpu_ack), 32'd0);
      check_val("reset_fill_busy", 32'(fill_busy), 32'd0);
      check_val("reset_disp_sel", 32'(disp_sel), 32'd0);
      @(negedge clk); rst = 1'b1;

      // ---------------- CPU store then load at 2048
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'd2048; cpu_wdata = 32'hdeadbeef;
      #1;
      check_val("st_ram_en", 32'(ram_en), 32'd1);
      check_val("st_ram_we", 32'(ram_we), 32'd1);
      check_val("st_ram_addr", 32'(ram_addr), 32'd2048);
      check_val("st_ram_wdata", ram_wdata, 32'hdeadbeef);
      check_val("st_ack_grant_cycle", 32'(cpu_ack), 32'd0);
      @(negedge clk); cpu_req = 1'b0; #1;
      check_val("st_ack", 32'(cpu_ack), 32'd1);
      check_val("st_rdata_zero", cpu_rdata, 32'd0);
      check_val("st_no_grant_in_ack", 32'(ram_en), 32'd0);
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_wdata = '0;
      #1;
      check_val("ld_ram_en", 32'(ram_en), 32'd1);
      check_val("ld_ram_we", 32'(ram_we), 32'd0);
      check_val("ld_ram_addr", 32'(ram_addr), 32'd2048);
      @(negedge clk); cpu_req = 1'b0; #1;
      check_val("ld_ack", 32'(cpu_ack), 32'd1);
      check_val("ld_rdata", cpu_rdata, 32'hdeadbeef);
      @(negedge clk); #1;
      check_val("ld_ack_pulse", 32'(cpu_ack), 32'd0);

      // ---------------- fill screen 1, no CPU traffic
      @(negedge clk);
      fill_start = 1'b1; fill_screen = 1'b1; fill_value = 32'h00000f00;
      #1;
      check_val("fill1_busy_start_cycle", 32'(fill_busy), 32'd0);
      good = 0;
      for (int c = 1; c <= 4800; c++) begin
         @(negedge clk); fill_start = 1'b0; #1;
         if (ram_en === 1'b1 && ram_we === 1'b1 && ram_addr === 14'(6848 + c - 1) &&
             ram_wdata === 32'h00000f00 && fill_busy === 1'b1 && fill_done === 1'b0)
            good++;
      end
      check_val("fill1_seq", 32'(good), 32'd4800);
      @(negedge clk); #1;
      check_val("fill1_done_4801", 32'(fill_done), 32'd1);
      check_val("fill1_busy_done", 32'(fill_busy), 32'd0);
      check_val("fill1_idle_port", 32'(ram_en), 32'd0);
      @(negedge clk); #1;
      check_val("fill1_done_pulse", 32'(fill_done), 32'd0);
      check_val("fill1_first_word", mem[6848], 32'h00000f00);
      check_val("fill1_last_word", mem[11647], 32'h00000f00);
      check_val("fill1_no_overrun", 32'(wr[11648]), 32'd0);
      check_val("fill1_no_underrun", 32'(wr[6847]), 32'd0);

      // ---------------- fill screen 0 with back-to-back CPU loads
      @(negedge clk);
      fill_start = 1'b1; fill_screen = 1'b0; fill_value = 32'h5a5a5a5a;
      #1;
      good = 0; acks = 0;
      for (int c = 1; c <= 9599; c++) begin
         @(negedge clk);
         fill_start = 1'b0;
         cpu_req = (c >= 2);
         cpu_we = 1'b0;
         if (c % 2 == 0) cpu_addr = 14'(12000 + (c / 2) % 64);
         #1;
         if (c % 2 == 1)
            ok = ram_en === 1'b1 && ram_we === 1'b1 && ram_addr === 14'(2048 + (c - 1) / 2) &&
                 ram_wdata === 32'h5a5a5a5a && cpu_ack === (c >= 3) &&
                 (c < 3 || cpu_rdata === dflt(12000 + ((c - 1) / 2) % 64));
         else
            ok = ram_en === 1'b1 && ram_we === 1'b0 && ram_addr === 14'(12000 + (c / 2) % 64) &&
                 cpu_ack === 1'b0;
         if (ok && fill_done === 1'b0) good++;
         if (cpu_ack === 1'b1) acks++;
      end
      check_val("mix_seq", 32'(good), 32'd9599);
      check_val("mix_acks", 32'(acks), 32'd4799);
      @(negedge clk); cpu_req = 1'b0; #1;
      check_val("mix_done_9600", 32'(fill_done), 32'd1);
      check_val("mix_done_port_idle", 32'(ram_en), 32'd0);
      @(negedge clk); #1;
      check_val("mix_done_pulse", 32'(fill_done), 32'd0);
      check_val("mix_overwrote_cpu", mem[2048], 32'h5a5a5a5a);
      check_val("mix_last_word", mem[6847], 32'h5a5a5a5a);

      // ---------------- display swap
      @(negedge clk); swap_req = 1'b1;
      @(negedge clk); swap_req = 1'b0;
      @(negedge clk); swap_req = 1'b1;
      @(negedge clk); swap_req = 1'b0; #1;
      check_val("swap_wait_vsync", 32'(disp_sel), 32'd0);
      @(negedge clk); vga_vs = 1'b0; #1;
      check_val("swap_before_edge", 32'(disp_sel), 32'd0);
      @(negedge clk); #1;
      check_val("swap_at_edge", 32'(disp_sel), 32'd1);
      repeat (3) @(negedge clk);
      vga_vs = 1'b1;
      repeat (3) @(negedge clk);
      vga_vs = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check_val("swap_collapsed", 32'(disp_sel), 32'd1);
      vga_vs = 1'b1;
      repeat (3) @(negedge clk);
      vga_vs = 1'b0; swap_req = 1'b1; #1;
      check_val("swap_same_before", 32'(disp_sel), 32'd1);
      @(negedge clk); swap_req = 1'b0; #1;
      check_val("swap_same_cycle", 32'(disp_sel), 32'd0);
      repeat (2) @(negedge clk);
      vga_vs = 1'b1;
      repeat (2) @(negedge clk);
      vga_vs = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check_val("swap_pend_cleared", 32'(disp_sel), 32'd0);
      swap_req = 1'b1;
      @(negedge clk); swap_req = 1'b0; vga_vs = 1'b1;
      repeat (2) @(negedge clk);
      vga_vs = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check_val("swap_pend_in_low", 32'(disp_sel), 32'd1);
      vga_vs = 1'b1;

      // ---------------- fill_start pulsed during RUN is ignored
      @(negedge clk);
      fill_start = 1'b1; fill_screen = 1'b0; fill_value = 32'h11111111;
      good = 0; dones = 0; done_cycle = 0;
      for (int c = 1; c <= 4820; c++) begin
         @(negedge clk);
         fill_start = (c == 10);
         fill_screen = (c == 10);
         if (c == 10) fill_value = 32'h22222222;
         #1;
         if (c <= 4800 && ram_en === 1'b1 && ram_we === 1'b1 &&
             ram_addr === 14'(2048 + c - 1) && ram_wdata === 32'h11111111)
            good++;
         if (fill_done === 1'b1) begin
            dones++;
            done_cycle = c;
         end
      end
      check_val("ign_seq", 32'(good), 32'd4800);
      check_val("ign_done_count", 32'(dones), 32'd1);
      check_val("ign_done_cycle", 32'(done_cycle), 32'd4801);
      check_val("ign_busy_after", 32'(fill_busy), 32'd0);

      // ---------------- reset during a fill (disp_sel is 1 here)
      @(negedge clk);
      fill_start = 1'b1; fill_screen = 1'b1; fill_value = 32'h33333333;
      @(negedge clk); fill_start = 1'b0;
      repeat (50) @(negedge clk);
      rst = 1'b0; cpu_req = 1'b1; cpu_we = 1'b1;
      @(negedge clk); #1;
      check_val("rst_fill_busy", 32'(fill_busy), 32'd0);
      check_val("rst_fill_done", 32'(fill_done), 32'd0);
      check_val("rst_ram_en", 32'(ram_en), 32'd0);
      check_val("rst_disp_sel", 32'(disp_sel), 32'd0);
      check_val("rst_cpu_ack", 32'(cpu_ack), 32'd0);
      @(negedge clk); cpu_req = 1'b0; cpu_we = 1'b0;
      @(negedge clk); rst = 1'b1;
      dones = 0; busy_seen = 0;
      for (int c = 0; c < 4810; c++) begin
         @(negedge clk); #1;
         if (fill_done === 1'b1) dones++;
         if (fill_busy === 1'b1 || ram_en === 1'b1) busy_seen++;
      end
      check_val("rst_no_done", 32'(dones), 32'd0);
      check_val("rst_no_activity", 32'(busy_seen), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
